// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus arbiter slice.
//   - state_t  : 3-bit FSM state encoding used by bus_arbiter
//   - OWN_*    : one-hot owner codes, bit order {cpu, dma, irq1, irq2}
//   - COUNT_W  : width of the DMA burst length / remaining-word count
//   - HOLD_W   : width of the DMA hold (beats-per-tenure) counter
//   - ACK_W    : width of the interrupt-acknowledge cycle counter
//   - grant_of : maps a state to the owner code it drives onto the grant lines
package bus_arb_pkg;

    localparam int COUNT_W = 6;
    localparam int HOLD_W  = 6;
    localparam int ACK_W   = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CPU  = 3'd1,
        ST_DMA  = 3'd2,
        ST_IRQ1 = 3'd3,
        ST_IRQ2 = 3'd4,
        ST_TURN = 3'd5
    } state_t;

    localparam logic [3:0] OWN_NONE = 4'b0000;
    localparam logic [3:0] OWN_CPU  = 4'b1000;
    localparam logic [3:0] OWN_DMA  = 4'b0100;
    localparam logic [3:0] OWN_IRQ1 = 4'b0010;
    localparam logic [3:0] OWN_IRQ2 = 4'b0001;

    function automatic logic [3:0] grant_of(input state_t st);
        case (st)
            ST_CPU:  grant_of = OWN_CPU;
            ST_DMA:  grant_of = OWN_DMA;
            ST_IRQ1: grant_of = OWN_IRQ1;
            ST_IRQ2: grant_of = OWN_IRQ2;
            default: grant_of = OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/dma_beat_counter.sv
// DMA burst accounting for the bus arbiter.
// Tracks the words remaining in the current (or suspended) burst and the
// number of beats taken in the present tenure.
// Ports:
//   clock, reset_n  : system clock (rising edge), async active-low reset
//   i_start         : tenure begins; clears the hold counter
//   i_load          : fresh burst; loads remaining = (i_count==0 ? 1 : i_count)
//   i_clear         : burst abandoned; clears remaining
//   i_beat          : one word transferred this cycle (already qualified by grant)
//   i_count         : requested burst length
//   o_left          : words remaining
//   o_last          : this beat completes the burst
//   o_hold_hit      : hold counter including this beat has reached MAX_HOLD
module dma_beat_counter
    import bus_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               i_start,
    input  logic               i_load,
    input  logic               i_clear,
    input  logic               i_beat,
    input  logic [COUNT_W-1:0] i_count,
    output logic [COUNT_W-1:0] o_left,
    output logic               o_last,
    output logic               o_hold_hit
);

    logic [COUNT_W-1:0] r_left;
    logic [HOLD_W-1:0]  r_hold;
    logic [HOLD_W:0]    w_hold_nxt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_left <= '0;
        end else if (i_clear) begin
            r_left <= '0;
        end else if (i_load) begin
            // A zero-length request still moves one word.
            r_left <= (i_count == '0) ? COUNT_W'(1) : i_count;
        end else if (i_beat && (r_left != '0)) begin
            r_left <= r_left - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hold <= '0;
        end else if (i_start) begin
            r_hold <= '0;
        end else if (i_beat && (r_hold != '1)) begin
            r_hold <= r_hold + 1'b1;
        end
    end

    // Look ahead by the current beat so the FSM can leave in the same cycle
    // the limit is reached.
    assign w_hold_nxt = {1'b0, r_hold} + {{HOLD_W{1'b0}}, i_beat};
    assign o_hold_hit = (w_hold_nxt >= (HOLD_W + 1)'(MAX_HOLD));
    assign o_last     = i_beat && (r_left == COUNT_W'(1));
    assign o_left     = r_left;

endmodule

// File: rtl/bus_arbiter.sv
// Owner scheduler for the shared address/data bus: processor, DMA and the
// two I/O interrupt sources. Grants are registered and one-hot; every change
// of owner passes through a one-cycle TURN (all grants low) and an IDLE
// arbitration cycle.
// Ports:
//   clock, reset_n      : system clock, async active-low reset
//   cpu_req, dma_req    : bus requests (levels)
//   dma_count           : burst length sampled at a fresh DMA grant
//   dma_beat            : DMA moved one word (ignored unless dma_gnt)
//   io_irq1, io_irq2    : interrupt pending levels
//   cpu_gnt, dma_gnt    : bus grants
//   io_ack1, io_ack2    : interrupt service strobes (ACK_CYCLES long)
//   busybus             : OR of all grants/acks
//   dma_left            : words remaining in current/suspended burst
//   dma_susp            : burst suspended by hold limit
// Configuration macro: ARB_STARVE_GUARD_EN enables the DMA starvation guard
// (forced DMA win after STARVE_LIMIT waiting cycles). Undefined = strict
// fixed priority.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int MAX_HOLD     = 16,
    parameter int ACK_CYCLES   = 1,
    parameter int STARVE_LIMIT = 32
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cpu_req,
    input  logic       dma_req,
    input  logic [5:0] dma_count,
    input  logic       dma_beat,
    input  logic       io_irq1,
    input  logic       io_irq2,
    output logic       cpu_gnt,
    output logic       dma_gnt,
    output logic       io_ack1,
    output logic       io_ack2,
    output logic       busybus,
    output logic [5:0] dma_left,
    output logic       dma_susp
);

    state_t             r_state;
    state_t             w_next_state;
    logic [3:0]         r_grant;
    logic               r_busy;
    logic               r_susp;
    logic [ACK_W-1:0]   r_ack_cnt;

    logic               w_start;
    logic               w_load;
    logic               w_clear;
    logic               w_susp_set;
    logic               w_susp_clr;
    logic               w_beat;
    logic               w_last;
    logic               w_hold_hit;
    logic               w_starve;
    logic [COUNT_W-1:0] w_left;

    // Beats outside a DMA tenure are not counted.
    assign w_beat = dma_beat && (r_state == ST_DMA);

    dma_beat_counter #(
        .MAX_HOLD (MAX_HOLD)
    ) u_cnt (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_start    (w_start),
        .i_load     (w_load),
        .i_clear    (w_clear),
        .i_beat     (w_beat),
        .i_count    (dma_count),
        .o_left     (w_left),
        .o_last     (w_last),
        .o_hold_hit (w_hold_hit)
    );

`ifdef ARB_STARVE_GUARD_EN
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    logic [WAIT_W-1:0] r_wait_cnt;

    // Saturates at the limit so the forced win stays armed until DMA is granted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
        end else if (r_grant[2]) begin
            r_wait_cnt <= '0;
        end else if (dma_req && (r_wait_cnt != WAIT_W'(STARVE_LIMIT))) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign w_starve = (r_wait_cnt == WAIT_W'(STARVE_LIMIT));
`else
    assign w_starve = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_load       = 1'b0;
        w_clear      = 1'b0;
        w_susp_set   = 1'b0;
        w_susp_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_starve && dma_req)  w_next_state = ST_DMA;
                else if (cpu_req)         w_next_state = ST_CPU;
                else if (io_irq1)         w_next_state = ST_IRQ1;
                else if (io_irq2)         w_next_state = ST_IRQ2;
                else if (dma_req)         w_next_state = ST_DMA;

                if (w_next_state == ST_DMA) begin
                    // A suspended burst resumes with its remaining count.
                    w_start    = 1'b1;
                    w_load     = !r_susp;
                    w_susp_clr = 1'b1;
                end else if (r_susp && !dma_req) begin
                    w_clear    = 1'b1;
                    w_susp_clr = 1'b1;
                end
            end
            ST_CPU: begin
                if (!cpu_req) w_next_state = ST_TURN;
            end
            ST_DMA: begin
                // Completion outranks a simultaneous request drop or hold limit.
                if (w_last) begin
                    w_next_state = ST_TURN;
                end else if (!dma_req) begin
                    w_clear      = 1'b1;
                    w_next_state = ST_TURN;
                end else if (w_hold_hit && cpu_req) begin
                    w_susp_set   = 1'b1;
                    w_next_state = ST_TURN;
                end
            end
            ST_IRQ1, ST_IRQ2: begin
                if (r_ack_cnt == ACK_W'(ACK_CYCLES - 1)) w_next_state = ST_TURN;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_grant   <= OWN_NONE;
            r_busy    <= 1'b0;
            r_susp    <= 1'b0;
            r_ack_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            // Grants are decoded from the next state so they are registered
            // and change on the same edge as the state.
            r_grant <= grant_of(w_next_state);
            r_busy  <= |grant_of(w_next_state);
            if (w_susp_set) begin
                r_susp <= 1'b1;
            end else if (w_susp_clr) begin
                r_susp <= 1'b0;
            end
            if (((r_state == ST_IRQ1) || (r_state == ST_IRQ2)) &&
                (w_next_state == r_state)) begin
                r_ack_cnt <= r_ack_cnt + 1'b1;
            end else begin
                r_ack_cnt <= '0;
            end
        end
    end

    assign cpu_gnt  = r_grant[3];
    assign dma_gnt  = r_grant[2];
    assign io_ack1  = r_grant[1];
    assign io_ack2  = r_grant[0];
    assign busybus  = r_busy;
    assign dma_left = w_left;
    assign dma_susp = r_susp;

endmodule
